// File: rtl/approx_error_sweeper.sv
// approx_error_sweeper
//   Sweeps every N_IN-bit input vector through an exact circuit and its
//   approximated counterpart (both external, fed from o_vec_out), compares
//   the two unsigned output words per vector and accumulates the worst-case
//   absolute error, the count of erroneous vectors and the first vector
//   that reached the worst error.
//   Circuit outputs arrive LAT cycles after the vector is driven; a LAT-deep
//   (valid, vec) tag line lines the vector up with its sampled results.
//   Optional build macro: APPROX_SWEEP_ABORT_EN -- stop issuing vectors at
//   the first sample whose error exceeds ET; in-flight vectors still drain.
module approx_error_sweeper #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 3,
    parameter int ET    = 4,
    parameter int LAT   = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    output logic [N_IN-1:0]   o_vec_out,
    output logic              o_vec_valid,
    input  logic [N_OUT-1:0]  i_exact_in,
    input  logic [N_OUT-1:0]  i_approx_in,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [N_OUT-1:0]  o_max_err,
    output logic [N_IN:0]     o_err_cnt,
    output logic [N_IN-1:0]   o_worst_vec
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};
    localparam logic [31:0]     ET_U     = 32'(ET);

    // Unsigned absolute difference; the result always fits in N_OUT bits.
    function automatic logic [N_OUT-1:0] abs_diff(input logic [N_OUT-1:0] a,
                                                  input logic [N_OUT-1:0] b);
        logic [N_OUT-1:0] d;
        if (a >= b) begin
            d = a - b;
        end else begin
            d = b - a;
        end
        return d;
    endfunction

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N_IN-1:0]   r_vec;
    logic              r_vec_valid;
    logic              r_busy;
    logic              r_done;
    logic              r_pass;
    logic [N_OUT-1:0]  r_max_err;
    logic [N_IN:0]     r_err_cnt;
    logic [N_IN-1:0]   r_worst_vec;

    logic              w_smp_valid;
    logic [N_IN-1:0]   w_smp_vec;
    logic              w_dl_pending;
    logic [N_OUT-1:0]  w_err;
    logic              w_over;
    logic              w_abort;
    logic              w_run_entry;
    logic              w_issue_stop;

    // Tag line aligning each issued vector with the cycle its results arrive.
    generate
        if (LAT == 0) begin : g_no_delay
            assign w_smp_valid  = r_vec_valid;
            assign w_smp_vec    = r_vec;
            assign w_dl_pending = 1'b0;
        end else begin : g_delay
            logic [LAT-1:0]            r_dl_valid;
            logic [LAT-1:0][N_IN-1:0]  r_dl_vec;

            // Shift (valid, vec) tags one stage per cycle.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    r_dl_valid <= '0;
                    r_dl_vec   <= '0;
                end else begin
                    r_dl_valid[0] <= r_vec_valid;
                    r_dl_vec[0]   <= r_vec;
                    for (int i = 1; i < LAT; i++) begin
                        r_dl_valid[i] <= r_dl_valid[i-1];
                        r_dl_vec[i]   <= r_dl_vec[i-1];
                    end
                end
            end

            assign w_smp_valid = r_dl_valid[LAT-1];
            assign w_smp_vec   = r_dl_vec[LAT-1];
            if (LAT == 1) begin : g_lat1
                assign w_dl_pending = 1'b0;
            end else begin : g_latn
                assign w_dl_pending = |r_dl_valid[LAT-2:0];
            end
        end
    endgenerate

    assign w_err  = abs_diff(i_exact_in, i_approx_in);
    assign w_over = ({{(32-N_OUT){1'b0}}, w_err} > ET_U);

`ifdef APPROX_SWEEP_ABORT_EN
    assign w_abort = (r_state == S_RUN) && w_smp_valid && w_over;
`else
    assign w_abort = 1'b0;
`endif

    assign w_run_entry  = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start;
    assign w_issue_stop = (r_state == S_RUN) && (w_abort || (r_vec == LAST_VEC));

    // Next-state logic; start is only honoured from IDLE or DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_RUN: begin
                if (w_issue_stop) begin
                    // With zero latency the last sample coincides with issue.
                    w_state_nxt = (LAT == 0) ? S_DONE : S_DRAIN;
                end else begin
                    w_state_nxt = S_RUN;
                end
            end
            S_DRAIN: begin
                // The stage being sampled now is the last live one.
                if (!w_dl_pending) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State, status flags, vector counter and error statistics.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_vec       <= '0;
            r_vec_valid <= 1'b0;
            r_pass      <= 1'b0;
            r_max_err   <= '0;
            r_err_cnt   <= '0;
            r_worst_vec <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_DRAIN);
            r_done  <= (w_state_nxt == S_DONE);

            if (w_run_entry) begin
                r_vec       <= '0;
                r_vec_valid <= 1'b1;
            end else if (w_issue_stop) begin
                r_vec       <= '0;
                r_vec_valid <= 1'b0;
            end else if (r_state == S_RUN) begin
                r_vec       <= r_vec + {{(N_IN-1){1'b0}}, 1'b1};
            end

            if (w_run_entry) begin
                r_pass      <= 1'b1;
                r_max_err   <= '0;
                r_err_cnt   <= '0;
                r_worst_vec <= '0;
            end else if (w_smp_valid) begin
                if (w_err != '0) begin
                    r_err_cnt <= r_err_cnt + {{N_IN{1'b0}}, 1'b1};
                end
                // Strictly greater: on a tie the earlier vector is kept.
                if (w_err > r_max_err) begin
                    r_max_err   <= w_err;
                    r_worst_vec <= w_smp_vec;
                end
                if (w_over) begin
                    r_pass <= 1'b0;
                end
            end
        end
    end

    assign o_vec_out   = r_vec;
    assign o_vec_valid = r_vec_valid;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_pass      = r_pass;
    assign o_max_err   = r_max_err;
    assign o_err_cnt   = r_err_cnt;
    assign o_worst_vec = r_worst_vec;

endmodule

// File: tb/tb_approx_error_sweeper.sv
// Bench for approx_error_sweeper (N_IN=4, N_OUT=3, ET=4, LAT=1).
// The external exact/approx circuits are lookup tables behind a one-cycle
// register; expected results come from a per-vector loop over those tables.
module tb_approx_error_sweeper;

    localparam int N_IN  = 4;
    localparam int N_OUT = 3;
    localparam int ET    = 4;
    localparam int LAT   = 1;
    localparam int NV    = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [N_IN-1:0]  vec_out;
    logic             vec_valid;
    logic [N_OUT-1:0] exact_in;
    logic [N_OUT-1:0] approx_in;
    logic             busy;
    logic             done;
    logic             pass;
    logic [N_OUT-1:0] max_err;
    logic [N_IN:0]    err_cnt;
    logic [N_IN-1:0]  worst_vec;

    logic [N_OUT-1:0] ex_tab [NV];
    logic [N_OUT-1:0] ap_tab [NV];
    logic [N_IN-1:0]  d_vec;

    int n_chk  = 0;
    int n_fail = 0;

    // expected results
    int e_pass, e_max, e_cnt, e_worst, e_nsamp;

    approx_error_sweeper #(.N_IN(N_IN), .N_OUT(N_OUT), .ET(ET), .LAT(LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_start     (start),
        .o_vec_out   (vec_out),
        .o_vec_valid (vec_valid),
        .i_exact_in  (exact_in),
        .i_approx_in (approx_in),
        .o_busy      (busy),
        .o_done      (done),
        .o_pass      (pass),
        .o_max_err   (max_err),
        .o_err_cnt   (err_cnt),
        .o_worst_vec (worst_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // external circuits with one cycle of latency
    always @(posedge clk) d_vec <= vec_out;
    assign exact_in  = ex_tab[d_vec];
    assign approx_in = ap_tab[d_vec];

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_popcount();
        for (int v = 0; v < NV; v++) begin
            ex_tab[v] = N_OUT'($countones(v));
            ap_tab[v] = ex_tab[v];
        end
    endtask

    // Reference: walk the vectors in order, stopping the sweep (in abort
    // builds) one vector after the first failure, since that one is in flight.
    task automatic model();
        int err;
        e_pass = 1; e_max = 0; e_cnt = 0; e_worst = 0; e_nsamp = NV;
        for (int k = 0; k < NV; k++) begin
            if (k < e_nsamp) begin
                err = int'(ex_tab[k]) - int'(ap_tab[k]);
                if (err < 0) err = -err;
                if (err != 0) e_cnt++;
                if (err > e_max) begin
                    e_max = err;
                    e_worst = k;
                end
                if (err > ET) begin
`ifdef APPROX_SWEEP_ABORT_EN
                    if (e_pass == 1) e_nsamp = (k + 2 < NV) ? k + 2 : NV;
`endif
                    e_pass = 0;
                end
            end
        end
    endtask

    // Run one sweep from IDLE/DONE and check timing and results.
    task automatic sweep(input string tag, input bit pulses);
        int cyc;
        int low_cyc;
        int seq_bad;
        model();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 1;
        low_cyc = 0;
        seq_bad = 0;
        chk({tag, ":c1_done"}, int'(done), 0);
        chk({tag, ":c1_busy"}, int'(busy), 1);
        chk({tag, ":c1_pass"}, int'(pass), 1);
        chk({tag, ":c1_cnt"}, int'(err_cnt), 0);
        chk({tag, ":c1_max"}, int'(max_err), 0);
        while (!done && cyc < 100) begin
            if (vec_valid) begin
                if (int'(vec_out) != cyc - 1) seq_bad++;
            end else if (low_cyc == 0) begin
                low_cyc = cyc;
            end
            start = pulses && (cyc == 5 || cyc == 9);
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
        end
        chk({tag, ":done_cycle"}, cyc, e_nsamp + 2);
        chk({tag, ":valid_low_cycle"}, low_cyc, e_nsamp + 1);
        chk({tag, ":vec_seq"}, seq_bad, 0);
        chk({tag, ":busy"}, int'(busy), 0);
        chk({tag, ":vec_out"}, int'(vec_out), 0);
        chk({tag, ":pass"}, int'(pass), e_pass);
        chk({tag, ":max_err"}, int'(max_err), e_max);
        chk({tag, ":err_cnt"}, int'(err_cnt), e_cnt);
        chk({tag, ":worst_vec"}, int'(worst_vec), e_worst);
        repeat (2) @(posedge clk);
        #1;
        chk({tag, ":done_hold"}, int'(done), 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        set_popcount();
        repeat (3) @(posedge clk);
        #1;
        chk("rst:vec_valid", int'(vec_valid), 0);
        chk("rst:busy", int'(busy), 0);
        chk("rst:done", int'(done), 0);
        chk("rst:pass", int'(pass), 0);
        chk("rst:max_err", int'(max_err), 0);
        chk("rst:err_cnt", int'(err_cnt), 0);
        chk("rst:worst_vec", int'(worst_vec), 0);
        chk("rst:vec_out", int'(vec_out), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: approx tied to exact
        sweep("exact", 1'b0);

        // 2: single error equal to ET at 4'hA
        set_popcount();
        ex_tab[10] = 3'd3;
        ap_tab[10] = 3'd7;
        sweep("et_boundary", 1'b0);

        // 3: two errors of 5 and one of 2, tie keeps earlier vector
        set_popcount();
        ap_tab[5]  = 3'd7;
        ap_tab[12] = 3'd7;
        ap_tab[1]  = 3'd3;
        sweep("tie", 1'b0);

        // 4: start pulses during the run are ignored
        sweep("start_busy", 1'b1);

        // 5: restart from DONE gives an identical sweep
        sweep("restart", 1'b0);

        // 6: asynchronous reset mid-sweep
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        chk("midrst:cnt_before", int'(err_cnt), 2);
        rst_n = 1'b0;
        #1;
        chk("midrst:vec_valid", int'(vec_valid), 0);
        chk("midrst:busy", int'(busy), 0);
        chk("midrst:pass", int'(pass), 0);
        chk("midrst:max_err", int'(max_err), 0);
        chk("midrst:err_cnt", int'(err_cnt), 0);
        chk("midrst:worst_vec", int'(worst_vec), 0);
        chk("midrst:vec_out", int'(vec_out), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("midrst:held_busy", int'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        sweep("after_rst", 1'b0);

        // 7: err=6 at vec 4'h3 only (abort case when the macro is set)
        set_popcount();
        ex_tab[3] = 3'd7;
        ap_tab[3] = 3'd1;
        sweep("abort", 1'b0);

        // 8: randomized error tables
        for (int r = 0; r < 6; r++) begin
            set_popcount();
            for (int v = 0; v < NV; v++) begin
                if ($urandom_range(0, 3) == 0) ap_tab[v] = N_OUT'($urandom_range(0, 7));
                if ($urandom_range(0, 5) == 0) ex_tab[v] = N_OUT'($urandom_range(0, 7));
            end
            sweep($sformatf("rand%0d", r), r[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/approx_error_sweeper.md
Name: approx_error_sweeper

Overview:
- Sequencer that exhaustively sweeps all 2^N_IN input vectors through an exact circuit and its XPAT/SOP-approximated counterpart (e.g. the abs_diff 4-in/3-out family) instantiated side by side.
- Compares both output words per vector as unsigned integers.
- Accumulates worst-case absolute error, error count and worst vector; flags pass/fail against the error threshold.
- Sits in the approximate-circuit verification harness; the exact and approximate circuits are external and fed from vec_out.

Parameters:
- N_IN, 4, number of circuit inputs; sweep length is 2^N_IN.
- N_OUT, 3, output word width of both circuits (unsigned integer).
- ET, 4, error threshold; a vector fails when |exact - approx| > ET.
- LAT, 1, cycles from vec_out driven to exact_in/approx_in valid (0..4; 0 = combinational, sampled in the same cycle).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- start  in  1  one-cycle pulse; begins a sweep from IDLE or DONE.
- vec_out  out  N_IN  input vector driven to both circuits.
- vec_valid  out  1  high while vec_out carries a live vector.
- exact_in  in  N_OUT  exact circuit output.
- approx_in  in  N_OUT  approximate circuit output.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; results stable.
- pass  out  1  1 if no vector exceeded ET; valid while done.
- max_err  out  N_OUT  largest |exact - approx| seen.
- err_cnt  out  N_IN+1  number of vectors with nonzero error (max 2^N_IN).
- worst_vec  out  N_IN  first vector that attained max_err.

Behaviour:
- Reset (async assert, sync release): state IDLE; vec_out=0, vec_valid=0, busy=0, done=0, pass=0, max_err=0, err_cnt=0, worst_vec=0, delay line cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -start-> RUN.
  - RUN -> DRAIN after vector 2^N_IN-1 is issued.
  - DRAIN -> DONE once the last vector has been sampled.
  - DONE -start-> RUN.
- RUN entry clears max_err, err_cnt, worst_vec; pass is set to 1 and vec counter to 0.
- Issue timing:
  - start sampled at edge 0.
  - Vectors k = 0..2^N_IN-1 are driven in cycles 1..2^N_IN, one per cycle, vec_valid=1 throughout.
  - vec_out wraps to 0 and vec_valid drops after the last vector.
- Sampling:
  - A LAT-deep shift register carries (valid, vec) tags.
  - The vector issued in cycle c is compared in cycle c+LAT.
  - LAT=0: compared in cycle c, DRAIN lasts zero cycles (RUN goes straight to DONE).
- Arithmetic per sample:
  - err = exact_in >= approx_in ? exact_in - approx_in : approx_in - exact_in, N_OUT bits, no overflow possible.
  - err != 0: err_cnt += 1.
  - err > max_err (strict): max_err <= err, worst_vec <= tag vec. Ties keep the earlier vector.
  - err > ET: pass <= 0 (sticky for the run). err == ET still passes.
- done rises the cycle after the final sample (cycle 2^N_IN+LAT+1) and holds until the next start.
- start while busy: ignored, no restart, stats untouched.
- start in the same cycle as the DRAIN->DONE transition: ignored; must be reissued in DONE.
- rst_n low mid-sweep: immediate return to the reset values above; no partial results retained.
- Outputs are registered, except vec_out, which comes directly from the vector counter register.

Optional Feature:
- Macro: APPROX_SWEEP_ABORT_EN.
- Defined:
  - The first sample with err > ET stops issue: vec_valid=0 from the next cycle.
  - Vectors already in flight are drained and still accounted.
  - FSM proceeds through DRAIN to DONE with pass=0; err_cnt and max_err cover only sampled vectors.
- Undefined: the full 2^N_IN sweep always runs regardless of failures.

Test Plan:
- Defaults, approx_in tied to exact_in (exact = popcount of vec delayed LAT) -> done high at cycle 18, pass=1, max_err=0, err_cnt=0, worst_vec=0.
- approx = exact except vec 4'hA, where exact=3 and approx=7 -> pass=1, max_err=4, err_cnt=1, worst_vec=4'hA (boundary err==ET passes).
- Errors of 5 at vec 4'h5 and 4'hC, 2 at vec 4'h1 -> pass=0, max_err=5, err_cnt=3, worst_vec=4'h5 (tie keeps earlier vector).
- Pulse start at cycles 5 and 9 of a run -> both ignored; done at cycle 18. Pulse start in DONE -> done=0 next cycle, stats cleared, second sweep identical to the first.
- Assert rst_n low at cycle 10 mid-sweep for 2 cycles -> all outputs 0 asynchronously, state IDLE; start afterwards yields a clean full sweep.
- With APPROX_SWEEP_ABORT_EN, LAT=1, err=6 at vec 4'h3 only -> vec_valid low from cycle 6, done at cycle 7, pass=0, max_err=6, err_cnt=1; without the macro, done at cycle 18 with the same stats.
